// File: rtl/ps2_alloc_pkg.sv
// Shared constants, FSM state encoding and event type for the PS/2 channel allocator.
// The optional auto-release feature is enabled with macro PS2_AUTO_RELEASE_EN.
package ps2_alloc_pkg;

    localparam logic [7:0] IDLE_CODE = 8'hF0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    // Controller chatter (BAT result, ACK, resend, errors) that never names a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Decodes the E0/F0 prefix grammar of the PS/2 byte stream into make/break events.
// Abandons a stale prefix after PREFIX_TIMEOUT idle cycles.
module ps2_prefix_fsm
    import ps2_alloc_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 500000
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       ev_valid,
    output ps2_event_t ev
);

    localparam int            TW      = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

    ps2_state_e    state;
    logic [TW-1:0] to_cnt;

    // Event is decoded straight from the current state so the parent's registers
    // update on the edge that accepts the completing byte.
    always_comb begin
        ev_valid = byte_valid;
        if (state == S_IDLE && (byte_data == PS2_BREAK || byte_data == PS2_EXT || is_ignored(byte_data)))
            ev_valid = 1'b0;
        if (state == S_EXT && byte_data == PS2_BREAK)
            ev_valid = 1'b0;
        ev.code = byte_data;
        ev.brk  = (state == S_BRK) || (state == S_EXT_BRK);
        ev.ext  = (state == S_EXT) || (state == S_EXT_BRK);
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else if (byte_valid) begin
            to_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (byte_data == PS2_BREAK)    state <= S_BRK;
                    else if (byte_data == PS2_EXT) state <= S_EXT;
                end
                S_EXT:   state <= (byte_data == PS2_BREAK) ? S_EXT_BRK : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (to_cnt == TO_LAST) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_channel_alloc.sv
// Allocates held PS/2 note keys onto two polyphonic channels for the staff block.
// Define PS2_AUTO_RELEASE_EN to release channels held AUTO_RELEASE_CYC cycles without a repeat.
module ps2_channel_alloc
    import ps2_alloc_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 500000
`ifdef PS2_AUTO_RELEASE_EN
    ,
    parameter int AUTO_RELEASE_CYC = 250000000
`endif
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic [7:0] scan_code1,
    output logic [7:0] scan_code2,
    output logic [7:0] key1_code,
    output logic       key_strobe,
    output logic       steal
);

    logic            ev_valid;
    ps2_event_t      ev;
    logic [1:0][7:0] ch;
    logic            oldest;
    logic [1:0]      hit, busy, expire;
    logic            is_make, alloc, sel;

    ps2_prefix_fsm #(.PREFIX_TIMEOUT(PREFIX_TIMEOUT)) u_fsm (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ev_valid   (ev_valid),
        .ev         (ev)
    );

    assign scan_code1 = ch[0];
    assign scan_code2 = ch[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hit[i]  = (ch[i] == ev.code);
            busy[i] = (ch[i] != IDLE_CODE);
        end
        is_make = ev_valid && !ev.brk && !ev.ext;
        alloc   = is_make && !(|hit);
        // Free ch1 first, then ch2, otherwise evict the older one.
        sel     = !busy[0] ? 1'b0 : (!busy[1] ? 1'b1 : oldest);
    end

`ifdef PS2_AUTO_RELEASE_EN
    localparam int            AW      = (AUTO_RELEASE_CYC > 2) ? $clog2(AUTO_RELEASE_CYC) : 1;
    localparam logic [AW-1:0] AR_LAST = AW'(AUTO_RELEASE_CYC - 1);

    logic [1:0][AW-1:0] age;

    // A repeat make arriving on the expiry cycle keeps the key alive.
    always_comb begin
        for (int i = 0; i < 2; i++)
            expire[i] = busy[i] && (age[i] == AR_LAST) && !(is_make && hit[i]);
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            age <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!busy[i] || expire[i] || (is_make && hit[i]) || (alloc && sel == i[0]))
                    age[i] <= '0;
                else
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    assign expire = '0;
`endif

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            ch         <= {IDLE_CODE, IDLE_CODE};
            key1_code  <= IDLE_CODE;
            oldest     <= 1'b0;
            key_strobe <= 1'b0;
            steal      <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            steal      <= 1'b0;
            for (int i = 0; i < 2; i++)
                if (expire[i]) ch[i] <= IDLE_CODE;
            if (ev_valid) begin
                if (ev.brk) begin
                    for (int i = 0; i < 2; i++)
                        if (hit[i]) ch[i] <= IDLE_CODE;
                    if (key1_code == ev.code) key1_code <= IDLE_CODE;
                end else if (ev.ext) begin
                    key1_code  <= ev.code;
                    key_strobe <= (ev.code != key1_code);
                end else begin
                    key1_code <= ev.code;
                    if (alloc) begin
                        ch[sel]    <= ev.code;
                        key_strobe <= 1'b1;
                        steal      <= busy[0] && busy[1];
                        // On a steal sel == oldest, so this also flips it.
                        oldest     <= ~sel;
                    end
                end
            end
        end
    end

endmodule
